// File: rtl/terrain_probe.sv
// Scans a range of terrain columns from SRAM, reports each column's surface row
// and the topmost surface found. Define TERRAIN_PROBE_STREAM_EN to expose per-column results.
module terrain_probe #(
  parameter int NCOLS = 640,
  parameter int NROWS = 480
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             terrain_ready,
  input  logic             start,
  input  logic [9:0]       x_start,
  input  logic [9:0]       x_count,
  output logic [9:0]       sram_read_addr,
  input  logic [NROWS-1:0] sram_q,
  output logic             busy,
  output logic             done,
  output logic             col_valid,
  output logic [9:0]       col_addr,
  output logic [9:0]       col_height,
  output logic [9:0]       min_height,
  output logic [9:0]       min_col
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [9:0]  LP_ROWS    = 10'(NROWS);
  localparam logic [9:0]  LP_LASTCOL = 10'(NCOLS - 1);
  localparam logic [10:0] LP_NCOLS   = 11'(NCOLS);

  state_t      r_state;
  logic [9:0]  r_addr;
  logic [9:0]  r_last;
  logic        r_v1;
  logic [9:0]  r_a1;
  logic        r_colValid;
  logic [9:0]  r_colAddr;
  logic [9:0]  r_colH;
  logic [9:0]  r_minH;
  logic [9:0]  r_minC;
  logic        r_busy;
  logic        r_done;

  logic [9:0]  w_cnt;
  logic [10:0] w_end;
  logic [9:0]  w_last;
  logic        w_inRange;
  logic [9:0]  w_surf;

  assign w_cnt     = (x_count == 10'd0) ? 10'd1 : x_count;
  assign w_end     = {1'b0, x_start} + {1'b0, w_cnt} - 11'd1;
  assign w_last    = (w_end > {1'b0, LP_LASTCOL}) ? LP_LASTCOL : w_end[9:0];
  assign w_inRange = ({1'b0, x_start} < LP_NCOLS);

  // Surface is the topmost set bit, i.e. the lowest index; NROWS for an empty column.
  always_comb begin
    w_surf = LP_ROWS;
    for (int i = NROWS - 1; i >= 0; i--) begin
      if (sram_q[i]) w_surf = 10'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_last     <= '0;
      r_v1       <= 1'b0;
      r_a1       <= '0;
      r_colValid <= 1'b0;
      r_colAddr  <= '0;
      r_colH     <= '0;
      r_minH     <= LP_ROWS;
      r_minC     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // Stage 1 tracks the address whose word arrives next cycle; stage 2 holds the result.
      r_v1       <= (r_state == SCAN);
      r_a1       <= r_addr;
      r_colValid <= r_v1;
      if (r_v1) begin
        r_colAddr <= r_a1;
        r_colH    <= w_surf;
      end
      if (r_colValid && (r_colH < r_minH)) begin
        r_minH <= r_colH;
        r_minC <= r_colAddr;
      end
      case (r_state)
        IDLE: begin
          if (start && terrain_ready) begin
            r_minH <= LP_ROWS;
            if (w_inRange) begin
              r_addr  <= x_start;
              r_last  <= w_last;
              r_minC  <= x_start;
              r_busy  <= 1'b1;
              r_state <= SCAN;
            end else begin
              r_minC  <= '0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        SCAN: begin
          if (r_addr == r_last) r_state <= DRAIN;
          else                  r_addr  <= r_addr + 10'd1;
        end
        DRAIN: begin
          // The final result is the one in stage 2 with nothing left behind it.
          if (!r_v1 && r_colValid) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sram_read_addr = r_addr;
  assign busy           = r_busy;
  assign done           = r_done;
  assign min_height     = r_minH;
  assign min_col        = r_minC;

`ifdef TERRAIN_PROBE_STREAM_EN
  assign col_valid  = r_colValid;
  assign col_addr   = r_colAddr;
  assign col_height = r_colH;
`else
  assign col_valid  = 1'b0;
  assign col_addr   = '0;
  assign col_height = '0;
`endif

endmodule

// File: doc/terrain_probe.md
TERRAIN_PROBE -- requirements
Module: terrain_probe

Interface
REQ-001 SHALL have parameters: NCOLS, 640, number of terrain columns. NROWS, 480, bits per column word, with bit 0 as the screen top.
REQ-002 SHALL have port clk  in  1  system clock, all state on its rising edge.
REQ-003 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port terrain_ready  in  1  terrain generation complete; start is ignored while this is low.
REQ-005 SHALL have port start  in  1  single-cycle request to begin a probe.
REQ-006 SHALL have port x_start  in  10  first column to probe.
REQ-007 SHALL have port x_count  in  10  number of columns to probe; 0 is treated as 1.
REQ-008 SHALL have port sram_read_addr  out  10  column address to the terrain SRAM read port.
REQ-009 SHALL have port sram_q  in  NROWS  column word from the SRAM, registered one cycle after the address.
REQ-010 SHALL have port busy  out  1  probe in progress.
REQ-011 SHALL have port done  out  1  single-cycle completion pulse.
REQ-012 SHALL have port col_valid  out  1  per-column result strobe.
REQ-013 SHALL have port col_addr  out  10  column number of the current result.
REQ-014 SHALL have port col_height  out  10  surface row of the current result.
REQ-015 SHALL have port min_height  out  10  topmost surface row over the probed range.
REQ-016 SHALL have port min_col  out  10  column at which min_height occurs.

Function
REQ-017 SHALL implement states IDLE, SCAN, DRAIN and DONE, entering IDLE after reset.
REQ-018 IDLE: SHALL accept start only when terrain_ready=1; it then latches x_start and last = min(x_start+max(x_count,1)-1, NCOLS-1), drives sram_read_addr=x_start and goes to SCAN.
REQ-019 IDLE: SHALL, if x_start>=NCOLS at start, skip scanning, go to DONE with min_height=NROWS and min_col=0, and issue no col_valid.
REQ-020 SCAN: SHALL increment sram_read_addr by 1 per cycle and go to DRAIN once the address equals last; there is no wrap past NCOLS-1.
REQ-021 Pipeline: SHALL compute the surface of each column from sram_q and register it, so col_valid for column x_start+k is high exactly 1 cycle, in the cycle after edge T0+2+k, where T0 is the start-accept edge; throughput is 1 column/cycle.
REQ-022 Surface SHALL be the lowest index i with sram_q[i]=1, or NROWS when the word is all zero.
REQ-023 min_height/min_col SHALL be initialised to NROWS/x_start at accept and update on each col_valid only when col_height<min_height (strictly less), so on a tie the lowest column wins.
REQ-024 DRAIN: SHALL wait until the last col_valid has been issued, then go to DONE.
REQ-025 DONE: SHALL hold done=1 for exactly one cycle with final min_height/min_col stable, then return to IDLE.
REQ-026 busy SHALL be 1 from the edge after start is accepted through the cycle before done, and 0 otherwise.
REQ-027 start SHALL be ignored while busy=1 or done=1.
REQ-028 min_height/min_col SHALL hold their value after done until the next accepted start.
REQ-029 sram_read_addr SHALL hold its last value when not in SCAN.

Reset
REQ-030 reset_n=0 SHALL immediately abort any probe with no done pulse, force IDLE, and clear pipeline valids.
REQ-031 Reset values SHALL be: busy=0, done=0, col_valid=0, col_addr=0, col_height=0, sram_read_addr=0, min_height=NROWS, min_col=0.

Configuration
REQ-032 With TERRAIN_PROBE_STREAM_EN defined, col_valid, col_addr and col_height SHALL operate per REQ-021.
REQ-033 Without TERRAIN_PROBE_STREAM_EN, col_valid, col_addr and col_height SHALL be tied to 0, while min_height, min_col, done and busy timing are unchanged.

Verification
REQ-034 Flat terrain (bits 290..479 set in all columns), x_start=0, x_count=640 -> 640 col_valid, each with col_height=290, done after edge T0+642, min_height=290, min_col=0.
REQ-035 Column 100 at height 50, others at 290, x_start=90, x_count=20 -> col_height=50 at col_addr=100, min_height=50, min_col=100.
REQ-036 Column 5 all zero, x_start=5, x_count=0 -> one col_valid with col_height=480, min_height=480, min_col=5.
REQ-037 x_start=630, x_count=20 -> exactly 10 col_valid (630..639) then done; x_start=700 -> done with no col_valid and min_height=480.
REQ-038 reset_n pulsed low during SCAN at column 5 -> all outputs at reset values asynchronously and no done; start with terrain_ready=0 -> busy stays 0.
